img_stream_gen: RTL

IMG_STREAM_GEN -- requirements
Module: img_stream_gen

---
 rtl/img_stream_gen.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/img_stream_gen.sv
// -----------------------------------------------------------------------------
// img_stream_gen
// Frame/line timing generator for an 8-bit gray pixel stream. It pulls pixels
// from a valid-only source during each active line and emits vsync/href/gray
// in the classic camera-port format.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          one-cycle frame request (honoured only while idle)
//   src_valid      source has a pixel on src_data
//   src_data[7:0]  source pixel
//   src_ready      combinational: pixel is consumed at the coming edge
//   per_img_vsync  frame valid (registered)
//   per_img_href   line valid (registered)
//   per_img_gray   pixel value, 0 outside href (registered)
//   busy           frame in progress (registered)
//   frame_done     one-cycle pulse in the first idle cycle after a frame
//   underrun       sticky: a pixel was starved in the current frame
//   underrun_cnt   starved pixels in the current frame, saturating
//
// V_FRONT, H_BLANK, V_BACK, IMG_HDISP and IMG_VDISP must all be >= 1.
// -----------------------------------------------------------------------------
module img_stream_gen #(
    parameter int unsigned IMG_HDISP = 512,
    parameter int unsigned IMG_VDISP = 512,
    parameter int unsigned V_FRONT   = 5,
    parameter int unsigned H_BLANK   = 5,
    parameter int unsigned V_BACK    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        per_img_vsync,
    output logic        per_img_href,
    output logic [7:0]  per_img_gray,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int unsigned COL_W  = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
    localparam int unsigned LINE_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;

    // Longest blanking interval sets the width of the shared phase counter.
    localparam int unsigned PH_MAX =
        (V_FRONT > H_BLANK) ? ((V_FRONT > V_BACK) ? V_FRONT : V_BACK)
                            : ((H_BLANK > V_BACK) ? H_BLANK : V_BACK);
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_HDISP - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_VDISP - 1);
    localparam logic [PH_W-1:0]   VF_LAST   = PH_W'(V_FRONT - 1);
    localparam logic [PH_W-1:0]   HB_LAST   = PH_W'(H_BLANK - 1);
    localparam logic [PH_W-1:0]   VB_LAST   = PH_W'(V_BACK - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_V_FRONT,
        ST_H_BLANK,
        ST_ACTIVE,
        ST_V_BACK
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PH_W-1:0]     r_phase;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    w_col_nxt;
    logic [LINE_W-1:0]   r_line;
    logic [LINE_W-1:0]   w_line_nxt;

    logic                w_src_ready;
    logic                w_frame_start;

    logic                r_vsync;
    logic                r_href;
    logic [7:0]          r_gray;
    logic                r_busy;
    logic                r_frame_done;
    logic                r_underrun;
    logic [15:0]         r_underrun_cnt;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
            r_col   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_col   <= w_col_nxt;
            r_line  <= w_line_nxt;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_V_FRONT;
                    w_phase_nxt = '0;
                    w_col_nxt   = '0;
                    w_line_nxt  = '0;
                end
            end

            ST_V_FRONT: begin
                if (r_phase == VF_LAST) begin
                    w_state_nxt = ST_H_BLANK;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            ST_H_BLANK: begin
                if (r_phase == HB_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_phase_nxt = '0;
                    w_col_nxt   = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            ST_ACTIVE: begin
                if (r_col == COL_LAST) begin
                    w_col_nxt   = '0;
                    w_phase_nxt = '0;
                    if (r_line == LINE_LAST) begin
                        w_line_nxt  = '0;
                        w_state_nxt = ST_V_BACK;
                    end else begin
                        w_line_nxt  = r_line + LINE_W'(1);
                        w_state_nxt = ST_H_BLANK;
                    end
                end else begin
                    w_col_nxt = r_col + COL_W'(1);
                end
            end

            ST_V_BACK: begin
                if (r_phase == VB_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
                w_col_nxt   = '0;
                w_line_nxt  = '0;
            end
        endcase
    end

    // A pixel is taken whenever the coming edge lands in ACTIVE, so ready
    // leads href by exactly one cycle.
    assign w_src_ready   = !rst && (w_state_nxt == ST_ACTIVE);
    assign w_frame_start = (r_state == ST_IDLE) && start;

    // Registered stream outputs, aligned with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync        <= 1'b0;
            r_href         <= 1'b0;
            r_gray         <= 8'h00;
            r_busy         <= 1'b0;
            r_frame_done   <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= 16'h0000;
        end else begin
            r_vsync      <= (w_state_nxt != ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_href       <= (w_state_nxt == ST_ACTIVE);
            r_frame_done <= (r_state == ST_V_BACK) && (w_state_nxt == ST_IDLE);
            // Starved pixels go out as black; the stream never stalls.
            r_gray       <= (w_src_ready && src_valid) ? src_data : 8'h00;

            if (w_frame_start) begin
                r_underrun     <= 1'b0;
                r_underrun_cnt <= 16'h0000;
            end else if (w_src_ready && !src_valid) begin
                r_underrun <= 1'b1;
                if (r_underrun_cnt != 16'hFFFF) begin
                    r_underrun_cnt <= r_underrun_cnt + 16'd1;
                end
            end
        end
    end

    assign src_ready     = w_src_ready;
    assign per_img_vsync = r_vsync;
    assign per_img_href  = r_href;
    assign per_img_gray  = r_gray;
    assign busy          = r_busy;
    assign frame_done    = r_frame_done;
    assign underrun      = r_underrun;
    assign underrun_cnt  = r_underrun_cnt;

endmodule
